psychic5_videogen: RTL and testbench
====================================

# psychic5_videogen

Video timing and test-pattern source for the Psychic 5 video path, driving the same H/V counter and 12-bit RGB bus that the screen-capture and downstream video blocks consume. It lets the capture and mixer stages be exercised standalone, without CPU, tilemap or sprite logic. It reproduces the game's 384×264 counter raster on the 6 MHz pixel enable. It emits a 256×224 active picture in one of four selectable patterns.

## Interface
Parameters:
- none; all raster constants live in the shared package.

Ports:
- i_EMU_MCLK  in  1  master clock; the only clock.
- i_EMU_MRST_n  in  1  asynchronous, active-low reset.
- i_EMU_CLK6MPCEN_n  in  1  active-low pixel clock enable; all state advances only on MCLK edges where it is low.
- i_PATSEL  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 gradient, 3 solid.
- i_SOLID  in  12  RGB444 colour for pattern 3.
- o_HCOUNTER  out  9  horizontal counter, 128..511.
- o_VCOUNTER  out  9  vertical counter, 248..511.
- o_HBLANK_n, o_VBLANK_n  out  1 each  blanking, low = blank.
- o_HSYNC_n, o_VSYNC_n  out  1 each  sync, low = active.
- o_VIDEODATA  out  12  {R[3:0],G[3:0],B[3:0]}.
- o_FRAME  out  16  completed-frame count.

## Operation
- H counts 128..511, then wraps to 128.
  - On each H wrap, V increments; V 511 wraps to 248.
  - Result: 384 × 264 enables per frame.
- Active lines: V 272..495; Y = V − 272.
- Active pixels of line Y:
  - H 269..511 of that line: X = H − 269, giving 0..242.
  - H 128..140 of the following counter line: X = H − 128 + 243, giving 243..255.
  - The 128..140 segment keeps the previous line's Y. The V=496, H 128..140 segment completes Y=223.
- Internal active flag:
  - Sets on entering H=269 when V is in 272..495.
  - Clears on entering H=141.
  - Y is latched when the flag sets.
- o_HBLANK_n is high exactly while the active flag is set.
- o_VBLANK_n is high for V 272..496.
- o_HSYNC_n is low for H 160..191; o_VSYNC_n is low for V 252..255.
- Patterns, using X[7:0] and Y[7:0]:
  - 0: eight 32-px vertical bars. Bar index b = X[7:5]; R = {4{b[2]}}, G = {4{b[1]}}, B = {4{b[0]}}.
  - 1: 8×8 checker. 12'hFFF when X[3]^Y[3], else 12'h000.
  - 2: R = X[7:4], G = Y[7:4], B = X[7:4]^Y[7:4].
  - 3: i_SOLID.
- Outside the active window, o_VIDEODATA = 12'h000.
- i_PATSEL and i_SOLID are sampled only on the V-wrap enable (start of frame). Mid-frame changes take effect next frame.
- o_FRAME increments on the V 511→248 wrap and wraps modulo 2^16.

## Timing
- Reset values:
  - H=128, V=248, active flag 0, Y=0.
  - o_VIDEODATA=0, o_FRAME=0.
  - Blank outputs low; sync outputs high.
  - Latched pattern = 0, latched solid = 0.
- All outputs are registered. On a given enable edge, counters, blank/sync flags and o_VIDEODATA update together.
- o_VIDEODATA always corresponds to the o_HCOUNTER/o_VCOUNTER values presented in the same cycle. The block computes next-state coordinates; there is zero lag between counter and data.
- With the enable high, every output holds.
- Reset asserted mid-frame: all state returns to reset values asynchronously. Counting resumes from H=128, V=248 on the first enable after release.

## Configuration
- PSYCHIC5_VIDEOGEN_SCROLL_EN
  - Defined: the X used for pattern lookup is (X + o_FRAME[7:0]) mod 256, so patterns scroll left one pixel per frame.
  - Undefined: X is used directly and the scroll adder is not built.
  - Timing and blanking are identical either way.

## Structure
- Package psychic5_video_pkg holds:
  - H/V limits: 128, 511, 248, 511.
  - Active boundaries: 269, 140, 141, 272, 495, 496.
  - Sync windows.
  - Pattern select enum.
- Sub-module psychic5_patterngen: maps {X, Y, pattern, solid} to RGB444 combinationally. The parent owns every register.

## Test plan
- Reset, then 101,376 enables -> o_FRAME=1; counters back at H=128, V=248; exactly 57,344 cycles with o_HBLANK_n high.
- Pattern 0, V=300, H=269 -> 12'h000. H=301 -> 12'h00F. V=301, H=140 (X=255) -> 12'hFFF.
- Pattern 3 with i_SOLID=12'hA5C, changed to 12'h123 at V=400 -> 12'hA5C for the rest of the frame; 12'h123 from the next frame.
- Enable held high for 50 MCLK at H=300 -> all outputs constant.
- Reset pulsed at V=350 -> outputs at reset values immediately; o_FRAME=0.
- With PSYCHIC5_VIDEOGEN_SCROLL_EN, pattern 0, frame 32, X=0 -> 12'h00F (bar 1).

Source files
------------

// File: rtl/psychic5_video_pkg.sv
// Shared raster constants and pattern encoding for the Psychic 5 video timing source.
package psychic5_video_pkg;

    // Counter limits: H runs 128..511, V runs 248..511 (384 x 264 enables per frame)
    localparam logic [8:0] HMin = 9'd128;
    localparam logic [8:0] HMax = 9'd511;
    localparam logic [8:0] VMin = 9'd248;
    localparam logic [8:0] VMax = 9'd511;

    // Active window: a picture line starts at H=269 and spills into H=128..140 of the next line
    localparam logic [8:0] HActStart = 9'd269;
    localparam logic [8:0] HActLast  = 9'd140;
    localparam logic [8:0] HActEnd   = 9'd141;
    localparam logic [8:0] VActStart = 9'd272;
    localparam logic [8:0] VActLast  = 9'd495;
    localparam logic [8:0] VVisLast  = 9'd496;

    // X of the first pixel in the spill-over segment (243)
    localparam logic [8:0] XTailBase = HMax - HActStart + 9'd1;

    // Sync windows (inclusive)
    localparam logic [8:0] HSyncStart = 9'd160;
    localparam logic [8:0] HSyncEnd   = 9'd191;
    localparam logic [8:0] VSyncStart = 9'd252;
    localparam logic [8:0] VSyncEnd   = 9'd255;

    typedef enum logic [1:0] {
        PatBars     = 2'd0,
        PatChecker  = 2'd1,
        PatGradient = 2'd2,
        PatSolid    = 2'd3
    } pat_e;

    // Inclusive range test on a 9-bit counter value
    function automatic logic in_range(input logic [8:0] val, input logic [8:0] lo,
                                      input logic [8:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/psychic5_patterngen.sv
// Combinational RGB444 test-pattern lookup from picture coordinates.
module psychic5_patterngen
    import psychic5_video_pkg::*;
(
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    input  logic [1:0]  pat_i,
    input  logic [11:0] solid_i,
    output logic [11:0] rgb_o
);

    // Select the pattern colour for this pixel
    always_comb begin
        rgb_o = 12'h000;
        unique case (pat_e'(pat_i))
            // Bar index is X[7:5]; each bit drives one full colour channel
            PatBars:     rgb_o = {{4{x_i[7]}}, {4{x_i[6]}}, {4{x_i[5]}}};
            PatChecker:  rgb_o = (x_i[3] ^ y_i[3]) ? 12'hFFF : 12'h000;
            PatGradient: rgb_o = {x_i[7:4], y_i[7:4], x_i[7:4] ^ y_i[7:4]};
            PatSolid:    rgb_o = solid_i;
            default:     rgb_o = 12'h000;
        endcase
    end

endmodule

// File: rtl/psychic5_videogen.sv
// Psychic 5 raster timing and test-pattern generator. Counters, blanking, sync and pixel data
// are all registered and advance together on the active-low 6 MHz enable; data is computed
// from next-state coordinates so it never lags the counters.
// Optional build macro: PSYCHIC5_VIDEOGEN_SCROLL_EN scrolls the pattern left one pixel/frame.
module psychic5_videogen
    import psychic5_video_pkg::*;
(
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_MRST_n,
    input  logic        i_EMU_CLK6MPCEN_n,
    input  logic [1:0]  i_PATSEL,
    input  logic [11:0] i_SOLID,
    output logic [8:0]  o_HCOUNTER,
    output logic [8:0]  o_VCOUNTER,
    output logic        o_HBLANK_n,
    output logic        o_VBLANK_n,
    output logic        o_HSYNC_n,
    output logic        o_VSYNC_n,
    output logic [11:0] o_VIDEODATA,
    output logic [15:0] o_FRAME
);

    logic [8:0]  h_q, h_d;
    logic [8:0]  v_q, v_d;
    logic        act_q, act_d;
    logic [7:0]  y_q, y_d;
    logic        hblank_n_q, hblank_n_d;
    logic        vblank_n_q, vblank_n_d;
    logic        hsync_n_q, hsync_n_d;
    logic        vsync_n_q, vsync_n_d;
    logic [11:0] video_q, video_d;
    logic [15:0] frame_q, frame_d;
    logic [1:0]  pat_q, pat_d;
    logic [11:0] solid_q, solid_d;

    logic        h_wrap;
    logic        v_wrap;
    logic [7:0]  x_d;
    logic [7:0]  x_pat;
    logic [11:0] rgb;

    // Raster counters: H wraps every 384 enables, V steps on each H wrap
    always_comb begin
        h_wrap = (h_q == HMax);
        v_wrap = h_wrap && (v_q == VMax);
        h_d    = h_wrap ? HMin : h_q + 9'd1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == VMax) ? VMin : v_q + 9'd1;
        end
    end

    // Active flag and latched picture row; the flag survives the H wrap so the
    // 128..140 spill-over segment keeps the previous line's Y
    always_comb begin
        act_d = act_q;
        y_d   = y_q;
        if ((h_d == HActStart) && in_range(v_d, VActStart, VActLast)) begin
            act_d = 1'b1;
            y_d   = 8'(v_d - VActStart);
        end else if (h_d == HActEnd) begin
            act_d = 1'b0;
        end
    end

    // Picture column for the next pixel; only meaningful while act_d is set
    always_comb begin
        if (h_d <= HActLast) begin
            x_d = 8'(h_d - HMin + XTailBase);
        end else begin
            x_d = 8'(h_d - HActStart);
        end
`ifdef PSYCHIC5_VIDEOGEN_SCROLL_EN
        x_pat = x_d + frame_q[7:0];
`else
        x_pat = x_d;
`endif
    end

    psychic5_patterngen u_patterngen (
        .x_i     (x_pat),
        .y_i     (y_d),
        .pat_i   (pat_q),
        .solid_i (solid_q),
        .rgb_o   (rgb)
    );

    // Frame counter and per-frame pattern latch, both updated only on the V wrap
    always_comb begin
        frame_d = frame_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        if (v_wrap) begin
            frame_d = frame_q + 16'd1;
            pat_d   = i_PATSEL;
            solid_d = i_SOLID;
        end
    end

    // Blanking, sync and pixel data derived from next-state coordinates
    always_comb begin
        hblank_n_d = act_d;
        vblank_n_d = in_range(v_d, VActStart, VVisLast);
        hsync_n_d  = !in_range(h_d, HSyncStart, HSyncEnd);
        vsync_n_d  = !in_range(v_d, VSyncStart, VSyncEnd);
        video_d    = act_d ? rgb : 12'h000;
    end

    // State registers: async reset, advance only on enabled MCLK edges
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
        if (!i_EMU_MRST_n) begin
            h_q        <= HMin;
            v_q        <= VMin;
            act_q      <= 1'b0;
            y_q        <= 8'd0;
            hblank_n_q <= 1'b0;
            vblank_n_q <= 1'b0;
            hsync_n_q  <= 1'b1;
            vsync_n_q  <= 1'b1;
            video_q    <= 12'h000;
            frame_q    <= 16'd0;
            pat_q      <= 2'd0;
            solid_q    <= 12'h000;
        end else if (!i_EMU_CLK6MPCEN_n) begin
            h_q        <= h_d;
            v_q        <= v_d;
            act_q      <= act_d;
            y_q        <= y_d;
            hblank_n_q <= hblank_n_d;
            vblank_n_q <= vblank_n_d;
            hsync_n_q  <= hsync_n_d;
            vsync_n_q  <= vsync_n_d;
            video_q    <= video_d;
            frame_q    <= frame_d;
            pat_q      <= pat_d;
            solid_q    <= solid_d;
        end
    end

    assign o_HCOUNTER  = h_q;
    assign o_VCOUNTER  = v_q;
    assign o_HBLANK_n  = hblank_n_q;
    assign o_VBLANK_n  = vblank_n_q;
    assign o_HSYNC_n   = hsync_n_q;
    assign o_VSYNC_n   = vsync_n_q;
    assign o_VIDEODATA = video_q;
    assign o_FRAME     = frame_q;

endmodule

// File: tb/tb_psychic5_videogen.sv
// Self-checking bench for psychic5_videogen: a position-indexed raster model predicts every
// output on every MCLK, with random enable stalls and random mid-frame pattern changes.
module tb_psychic5_videogen;

    localparam int HN = 384;
    localparam int VN = 264;
    localparam int FN = HN * VN;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en_n = 1'b1;
    logic [1:0]  patsel = 2'd0;
    logic [11:0] solid = 12'h000;
    logic [8:0]  o_hcnt, o_vcnt;
    logic        o_hblank_n, o_vblank_n, o_hsync_n, o_vsync_n;
    logic [11:0] o_video;
    logic [15:0] o_frame;

    // Direct probe of the pattern lookup
    logic [7:0]  pg_x, pg_y;
    logic [1:0]  pg_pat;
    logic [11:0] pg_solid, pg_rgb;

    int total = 0;
    int bad = 0;
    int m_t = 0;       // enables taken since reset = raster position
    int m_pat = 0;
    int m_solid = 0;
    int act_cnt = 0;

    psychic5_videogen dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_MRST_n      (rst_n),
        .i_EMU_CLK6MPCEN_n (en_n),
        .i_PATSEL          (patsel),
        .i_SOLID           (solid),
        .o_HCOUNTER        (o_hcnt),
        .o_VCOUNTER        (o_vcnt),
        .o_HBLANK_n        (o_hblank_n),
        .o_VBLANK_n        (o_vblank_n),
        .o_HSYNC_n         (o_hsync_n),
        .o_VSYNC_n         (o_vsync_n),
        .o_VIDEODATA       (o_video),
        .o_FRAME           (o_frame)
    );

    psychic5_patterngen u_pg (
        .x_i     (pg_x),
        .y_i     (pg_y),
        .pat_i   (pg_pat),
        .solid_i (pg_solid),
        .rgb_o   (pg_rgb)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mh(input int t);
        return 128 + t % HN;
    endfunction

    function automatic int mv(input int t);
        return 248 + (t / HN) % VN;
    endfunction

    // Which picture pixel (if any) the counter position shows
    function automatic bit m_active(input int h, input int v, output int x, output int y);
        x = 0;
        y = 0;
        if (h >= 269 && v >= 272 && v <= 495) begin
            x = h - 269;
            y = v - 272;
            return 1'b1;
        end
        if (h <= 140 && v >= 273 && v <= 496) begin
            x = h - 128 + 243;
            y = v - 273;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int m_rgb(input int pat, input int sol, input int x, input int y);
        int b, r, g;
        case (pat)
            0: begin
                b = x / 32;
                return ((b & 4) != 0 ? 'hF00 : 0) + ((b & 2) != 0 ? 'h0F0 : 0) +
                       ((b & 1) != 0 ? 'h00F : 0);
            end
            1: return (((x / 8) + (y / 8)) % 2 == 1) ? 'hFFF : 0;
            2: begin
                r = x / 16;
                g = y / 16;
                return r * 256 + g * 16 + (r ^ g);
            end
            default: return sol;
        endcase
    endfunction

    task automatic check_all();
        int h, v, x, y, f, xs, ev;
        bit a;
        h = mh(m_t);
        v = mv(m_t);
        f = (m_t / FN) % 65536;
        a = m_active(h, v, x, y);
`ifdef PSYCHIC5_VIDEOGEN_SCROLL_EN
        xs = (x + f) % 256;
`else
        xs = x;
`endif
        ev = a ? m_rgb(m_pat, m_solid, xs, y) : 0;
        chk("hcounter", 64'(o_hcnt), 64'(h));
        chk("vcounter", 64'(o_vcnt), 64'(v));
        chk("hblank_n", 64'(o_hblank_n), 64'(a));
        chk("vblank_n", 64'(o_vblank_n), 64'((v >= 272 && v <= 496) ? 1 : 0));
        chk("hsync_n", 64'(o_hsync_n), 64'((h >= 160 && h <= 191) ? 0 : 1));
        chk("vsync_n", 64'(o_vsync_n), 64'((v >= 252 && v <= 255) ? 0 : 1));
        chk("video", 64'(o_video), 64'(ev));
        chk("frame", 64'(o_frame), 64'(f));
    endtask

    task automatic tick(input bit en);
        en_n = !en;
        @(posedge clk);
        #1;
        if (en) begin
            m_t++;
            if (m_t % FN == 0) begin
                m_pat = patsel;
                m_solid = solid;
            end
            if (m_t < FN && o_hblank_n === 1'b1) act_cnt++;
        end
        check_all();
    endtask

    task automatic rnd_tick();
        tick($urandom_range(0, 15) != 0);
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 250000 && !(mh(m_t) == h && mv(m_t) == v); i++) rnd_tick();
        chk("reach", {o_hcnt, o_vcnt}, 64'((h << 9) | v));
    endtask

    initial begin
        #1 rst_n = 1'b0;

        // Pattern lookup exercised directly across all four patterns
        for (int i = 0; i < 400; i++) begin
            pg_x = 8'($urandom);
            pg_y = 8'($urandom);
            pg_pat = 2'(i % 4);
            pg_solid = 12'($urandom);
            #1;
            chk("patterngen", 64'(pg_rgb), 64'(m_rgb(pg_pat, pg_solid, pg_x, pg_y)));
        end

        // Reset state
        chk("rst_h", 64'(o_hcnt), 64'd128);
        chk("rst_v", 64'(o_vcnt), 64'd248);
        chk("rst_blank", {o_hblank_n, o_vblank_n}, 64'd0);
        chk("rst_sync", {o_hsync_n, o_vsync_n}, 64'd3);
        chk("rst_video", 64'(o_video), 64'd0);
        chk("rst_frame", 64'(o_frame), 64'd0);
        check_all();

        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0 shows bars (reset latch) regardless of inputs changing mid-frame
        patsel = 2'($urandom_range(1, 3));
        solid = 12'($urandom);
        run_to(269, 300);
        chk("bars_x0", 64'(o_video), 64'h000);
        run_to(300, 300);
        for (int i = 0; i < 50; i++) begin
            tick(1'b0);
            chk("hold_h", 64'(o_hcnt), 64'd300);
            chk("hold_v", 64'(o_vcnt), 64'd300);
        end
        run_to(301, 300);
        chk("bars_x32", 64'(o_video), 64'h00F);
        run_to(140, 301);
        chk("bars_x255", 64'(o_video), 64'hFFF);
        run_to(128, 400);
        patsel = 2'($urandom);
        solid = 12'($urandom);
        run_to(128, 480);
        patsel = 2'd2;
        solid = 12'hA5C;

        // Frame wrap: counter, active-pixel total, gradient latched for frame 1
        run_to(128, 248);
        chk("frame_one", 64'(o_frame), 64'd1);
        chk("active_count", 64'(act_cnt), 64'd57344);
        run_to(128, 260);
        patsel = 2'd3;
        solid = 12'h123;
        run_to(309, 290);
        chk("gradient_x40_y18", 64'(o_video), 64'h213);

        // Asynchronous reset mid-frame
        #2 rst_n = 1'b0;
        #1;
        chk("arst_h", 64'(o_hcnt), 64'd128);
        chk("arst_v", 64'(o_vcnt), 64'd248);
        chk("arst_blank", {o_hblank_n, o_vblank_n}, 64'd0);
        chk("arst_sync", {o_hsync_n, o_vsync_n}, 64'd3);
        chk("arst_video", 64'(o_video), 64'd0);
        chk("arst_frame", 64'(o_frame), 64'd0);
        m_t = 0;
        m_pat = 0;
        m_solid = 0;
        patsel = 2'd1;
        @(negedge clk);
        rst_n = 1'b1;
        run_to(301, 272);
        chk("post_rst_bars", 64'(o_video), 64'h00F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
